// File: rtl/fir_stream_host.sv
// rtl/fir_stream_host.sv - sample-side host for the fp32 FIR engine
//
// Buffers upstream samples in an input FIFO and feeds them to the FIR one per
// fir_next strobe. FIR results flagged by fir_ready go into a show-ahead
// output FIFO. After num_samples consumptions it raises fir_stop, waits for the
// final result, pulses done and returns to idle.
//
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   wr_en_i, wr_data_i, full_o   upstream sample write side
//   run_i, num_samples_i         run start and length (0 behaves as 1)
//   fir_sample_o, fir_next_i     sample presented to the FIR / consume strobe
//   fir_ready_i, fir_result_i    FIR result strobe and data
//   fir_stop_o                   end-of-run indication to the FIR
//   rd_en_i, rd_data_o, empty_o  result read side (show-ahead)
//   busy_o, done_o               run status
//   underrun_o, overflow_o       sticky error flags, cleared on run

module fir_stream_host #(
   parameter int IN_DEPTH  = 16,
   parameter int OUT_DEPTH = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wr_en_i,
   input  logic [31:0] wr_data_i,
   output logic        full_o,
   input  logic        run_i,
   input  logic [15:0] num_samples_i,
   output logic [31:0] fir_sample_o,
   input  logic        fir_next_i,
   input  logic        fir_ready_i,
   input  logic [31:0] fir_result_i,
   output logic        fir_stop_o,
   input  logic        rd_en_i,
   output logic [31:0] rd_data_o,
   output logic        empty_o,
   output logic        busy_o,
   output logic        done_o,
   output logic        underrun_o,
   output logic        overflow_o
);

   localparam int IAW = $clog2(IN_DEPTH);
   localparam int OAW = $clog2(OUT_DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_STREAM,
      ST_DRAIN,
      ST_DONE
   } state_t;

   state_t      state_q;
   logic [15:0] remaining_q;
   logic        fir_stop_q;
   logic        done_q;
   logic        underrun_q;
   logic        overflow_q;

   logic [31:0]  in_mem  [IN_DEPTH];
   logic [31:0]  out_mem [OUT_DEPTH];
   logic [IAW:0] in_wptr_q, in_wptr_d, in_rptr_q, in_rptr_d;
   logic [OAW:0] out_wptr_q, out_wptr_d, out_rptr_q, out_rptr_d;

   logic in_empty, in_full, out_empty, out_full;
   logic in_push, in_pop, out_req, out_push, out_pop, out_drop;

   // Pointers carry one extra wrap bit: equal pointers mean empty, equal
   // addresses with differing wrap bits mean full.
   always_comb begin
      in_empty   = (in_wptr_q == in_rptr_q);
      in_full    = (in_wptr_q[IAW] != in_rptr_q[IAW]) &&
                   (in_wptr_q[IAW-1:0] == in_rptr_q[IAW-1:0]);
      out_empty  = (out_wptr_q == out_rptr_q);
      out_full   = (out_wptr_q[OAW] != out_rptr_q[OAW]) &&
                   (out_wptr_q[OAW-1:0] == out_rptr_q[OAW-1:0]);

      // A write while full is dropped even if a pop frees a slot this cycle.
      in_push    = wr_en_i && !in_full;
      in_pop     = (state_q == ST_STREAM) && fir_next_i && !in_empty;

      // A result arriving while full is dropped even if a read frees a slot.
      out_req    = fir_ready_i && ((state_q == ST_STREAM) || (state_q == ST_DRAIN));
      out_push   = out_req && !out_full;
      out_drop   = out_req && out_full;
      out_pop    = rd_en_i && !out_empty;

      in_wptr_d  = in_wptr_q  + {{IAW{1'b0}}, in_push};
      in_rptr_d  = in_rptr_q  + {{IAW{1'b0}}, in_pop};
      out_wptr_d = out_wptr_q + {{OAW{1'b0}}, out_push};
      out_rptr_d = out_rptr_q + {{OAW{1'b0}}, out_pop};
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         in_wptr_q  <= '0;
         in_rptr_q  <= '0;
         out_wptr_q <= '0;
         out_rptr_q <= '0;
      end else begin
         in_wptr_q  <= in_wptr_d;
         in_rptr_q  <= in_rptr_d;
         out_wptr_q <= out_wptr_d;
         out_rptr_q <= out_rptr_d;
      end
   end

   // Storage arrays are not reset; reads are masked while a FIFO is empty.
   always_ff @(posedge clk_i) begin
      if (in_push) begin
         in_mem[in_wptr_q[IAW-1:0]] <= wr_data_i;
      end
      if (out_push) begin
         out_mem[out_wptr_q[OAW-1:0]] <= fir_result_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         fir_stop_q  <= 1'b0;
         done_q      <= 1'b0;
         underrun_q  <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (out_drop) begin
            overflow_q <= 1'b1;
         end
         case (state_q)
            ST_IDLE: begin
               fir_stop_q <= 1'b0;
               if (run_i) begin
                  remaining_q <= (num_samples_i == 16'd0) ? 16'd1 : num_samples_i;
                  underrun_q  <= 1'b0;
                  overflow_q  <= 1'b0;
                  state_q     <= ST_STREAM;
               end
            end
            ST_STREAM: begin
               // Every consume strobe counts toward the run, even when the
               // FIFO had nothing to give (that case is flagged as underrun).
               if (fir_next_i) begin
                  if (in_empty) begin
                     underrun_q <= 1'b1;
                  end
                  remaining_q <= remaining_q - 16'd1;
                  if (remaining_q == 16'd1) begin
                     fir_stop_q <= 1'b1;
                     state_q    <= ST_DRAIN;
                  end
               end
            end
            ST_DRAIN: begin
               if (fir_ready_i) begin
                  fir_stop_q <= 1'b0;
                  done_q     <= 1'b1;
                  state_q    <= ST_DONE;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign full_o       = in_full;
   assign empty_o      = out_empty;
   assign fir_sample_o = ((state_q == ST_STREAM) && !in_empty) ?
                         in_mem[in_rptr_q[IAW-1:0]] : 32'd0;
   assign rd_data_o    = out_empty ? 32'd0 : out_mem[out_rptr_q[OAW-1:0]];
   assign fir_stop_o   = fir_stop_q;
   assign busy_o       = (state_q != ST_IDLE);
   assign done_o       = done_q;
   assign underrun_o   = underrun_q;
   assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_fir_stream_host.sv
// tb/tb_fir_stream_host.sv - self-checking bench for fir_stream_host

module tb_fir_stream_host;

   localparam int IN_DEPTH  = 16;
   localparam int OUT_DEPTH = 16;
   localparam int P_IDLE = 0, P_STREAM = 1, P_DRAIN = 2, P_DONE = 3;

   logic        clk, rst;
   logic        wr_en, run, fir_next, fir_ready, rd_en;
   logic [31:0] wr_data, fir_result;
   logic [15:0] num_samples;
   logic        full, fir_stop, empty, busy, done, underrun, overflow;
   logic [31:0] fir_sample, rd_data;

   int vectors = 0;
   int miscompares = 0;

   fir_stream_host #(.IN_DEPTH(IN_DEPTH), .OUT_DEPTH(OUT_DEPTH)) dut (
      .clk_i(clk), .rst_i(rst),
      .wr_en_i(wr_en), .wr_data_i(wr_data), .full_o(full),
      .run_i(run), .num_samples_i(num_samples),
      .fir_sample_o(fir_sample), .fir_next_i(fir_next),
      .fir_ready_i(fir_ready), .fir_result_i(fir_result),
      .fir_stop_o(fir_stop),
      .rd_en_i(rd_en), .rd_data_o(rd_data), .empty_o(empty),
      .busy_o(busy), .done_o(done),
      .underrun_o(underrun), .overflow_o(overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: two queues, a run phase, a sample counter, two flags.
   logic [31:0] mq_in[$];
   logic [31:0] mq_out[$];
   int          ph = P_IDLE;
   int          m_rem = 0;
   logic        m_unr = 1'b0, m_ovf = 1'b0;
   bit          m_cap, m_capok, m_rdok, m_wrok, m_cons;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq_in.delete();
         mq_out.delete();
         ph    = P_IDLE;
         m_rem = 0;
         m_unr = 1'b0;
         m_ovf = 1'b0;
      end else begin
         m_cap   = ((ph == P_STREAM) || (ph == P_DRAIN)) && fir_ready;
         m_capok = m_cap && (mq_out.size() < OUT_DEPTH);
         m_rdok  = rd_en && (mq_out.size() > 0);
         m_wrok  = wr_en && (mq_in.size() < IN_DEPTH);
         m_cons  = (ph == P_STREAM) && fir_next;
         if (m_rdok) void'(mq_out.pop_front());
         if (m_capok) mq_out.push_back(fir_result);
         if (m_cap && !m_capok) m_ovf = 1'b1;
         if (m_cons) begin
            if (mq_in.size() > 0) void'(mq_in.pop_front());
            else m_unr = 1'b1;
            m_rem--;
         end
         if (m_wrok) mq_in.push_back(wr_data);
         case (ph)
            P_IDLE:
               if (run) begin
                  m_rem = (num_samples == 0) ? 1 : int'(num_samples);
                  m_unr = 1'b0;
                  m_ovf = 1'b0;
                  ph    = P_STREAM;
               end
            P_STREAM: if (m_cons && m_rem == 0) ph = P_DRAIN;
            P_DRAIN:  if (fir_ready) ph = P_DONE;
            default:  ph = P_IDLE;
         endcase
      end
   end

   // Compare process: every output against the model, on every falling edge.
   always @(negedge clk) begin
      chk("fir_sample", fir_sample,
          (ph == P_STREAM && mq_in.size() > 0) ? mq_in[0] : 32'd0);
      chk("full", {31'd0, full}, {31'd0, mq_in.size() == IN_DEPTH});
      chk("empty", {31'd0, empty}, {31'd0, mq_out.size() == 0});
      chk("rd_data", rd_data, (mq_out.size() > 0) ? mq_out[0] : 32'd0);
      chk("fir_stop", {31'd0, fir_stop}, {31'd0, ph == P_DRAIN});
      chk("busy", {31'd0, busy}, {31'd0, ph != P_IDLE});
      chk("done", {31'd0, done}, {31'd0, ph == P_DONE});
      chk("underrun", {31'd0, underrun}, {31'd0, m_unr});
      chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
   end

   task automatic clk1();
      @(posedge clk);
      #2;
   endtask
   task automatic wr(input logic [31:0] d);
      wr_en = 1'b1; wr_data = d; clk1(); wr_en = 1'b0;
   endtask
   task automatic nxt();
      fir_next = 1'b1; clk1(); fir_next = 1'b0;
   endtask
   task automatic rdy(input logic [31:0] r);
      fir_ready = 1'b1; fir_result = r; clk1(); fir_ready = 1'b0;
   endtask
   task automatic start(input logic [15:0] n);
      run = 1'b1; num_samples = n; clk1(); run = 1'b0;
   endtask
   task automatic pop();
      rd_en = 1'b1; clk1(); rd_en = 1'b0;
   endtask

   logic [31:0] vals1 [4] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};

   initial begin
      rst = 1'b1;
      wr_en = 0; run = 0; fir_next = 0; fir_ready = 0; rd_en = 0;
      wr_data = 0; fir_result = 0; num_samples = 0;
      clk1(); clk1();
      chk("rst_fir_sample", fir_sample, 32'd0);
      chk("rst_empty", {31'd0, empty}, 32'd1);
      chk("rst_full", {31'd0, full}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      clk1();

      // Four samples, four consumes, one drained result.
      for (int i = 0; i < 4; i++) wr(vals1[i]);
      start(16'd4);
      chk("s1_busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         chk("s1_sample", fir_sample, vals1[i]);
         nxt();
         if ($urandom_range(0, 1) == 1) clk1();
      end
      chk("s1_stop", {31'd0, fir_stop}, 32'd1);
      rdy(32'h41200000);
      chk("s1_done", {31'd0, done}, 32'd1);
      chk("s1_result", rd_data, 32'h41200000);
      clk1();
      chk("s1_done_low", {31'd0, done}, 32'd0);
      chk("s1_busy_low", {31'd0, busy}, 32'd0);
      pop();
      chk("s1_empty", {31'd0, empty}, 32'd1);

      // Underrun: three consumes with a single buffered sample.
      wr(32'h12345678);
      start(16'd3);
      nxt();
      chk("s2_sample_zero", fir_sample, 32'd0);
      nxt();
      nxt();
      chk("s2_underrun", {31'd0, underrun}, 32'd1);
      chk("s2_stop", {31'd0, fir_stop}, 32'd1);
      rdy(32'h00000001);
      clk1();
      pop();

      // Output overflow: 17 results with no reads.
      start(16'd2);
      chk("s3_underrun_clr", {31'd0, underrun}, 32'd0);
      for (int i = 0; i < 17; i++) rdy(32'h41000000 + i);
      chk("s3_overflow", {31'd0, overflow}, 32'd1);
      nxt();
      nxt();
      rdy(32'hFFFFFFFF);
      clk1();
      for (int i = 0; i < 16; i++) begin
         chk("s3_order", rd_data, 32'h41000000 + i);
         pop();
      end
      chk("s3_empty", {31'd0, empty}, 32'd1);

      // Input full: 17th write ignored, pointers wrap across the run.
      for (int i = 0; i < 16; i++) wr(32'hC0000000 + i);
      chk("s4_full", {31'd0, full}, 32'd1);
      wr(32'hDEADBEEF);
      chk("s4_full_hold", {31'd0, full}, 32'd1);
      start(16'd16);
      for (int i = 0; i < 16; i++) begin
         chk("s4_sample", fir_sample, 32'hC0000000 + i);
         nxt();
      end
      chk("s4_stop", {31'd0, fir_stop}, 32'd1);
      chk("s4_not_full", {31'd0, full}, 32'd0);
      rdy(32'h00000005);
      clk1();
      pop();

      // Randomised runs, including num_samples of 0.
      for (int r = 0; r < 12; r++) begin
         int c;
         run = 1'b1;
         num_samples = 16'($urandom_range(0, 20));
         c = 0;
         do begin
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_data    = $urandom;
            fir_next   = ($urandom_range(0, 2) == 0);
            fir_ready  = ($urandom_range(0, 2) == 0);
            fir_result = $urandom;
            rd_en      = ($urandom_range(0, 1) == 1);
            clk1();
            run = 1'b0;
            c++;
         end while (busy && c < 400);
         wr_en = 0; fir_next = 0; fir_ready = 0; rd_en = 0;
         chk("rand_run_timeout", {31'd0, busy}, 32'd0);
         clk1();
      end

      // Asynchronous reset in the middle of a run.
      for (int i = 0; i < 3; i++) wr(32'h3F000000 + i);
      start(16'd5);
      nxt();
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("arst_fir_sample", fir_sample, 32'd0);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_empty", {31'd0, empty}, 32'd1);
      chk("arst_full", {31'd0, full}, 32'd0);
      chk("arst_rd_data", rd_data, 32'd0);
      clk1();
      rst = 1'b0;
      clk1();
      clk1();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
